regfile_scoreboard: RTL and testbench

Integer register file plus pending-write scoreboard for the 5-stage RISC-V core. Sits between ID and WB. It accepts the write-back result from `wb_stage` (`wb_data` plus destination and write enable) and serves two combinational read ports to ID with WB→ID bypass. It tracks in-flight writes per register and raises `id_stall` on a RAW hazard that cannot be served this cycle.

---
 rtl/regfile_scoreboard_pkg.sv | 15 +
 rtl/regfile_scoreboard_pending_counter_bank.sv | 58 +++++
 rtl/regfile_scoreboard.sv | 90 +++++++++
 tb/tb_regfile_scoreboard.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared constants for the register file and pending-write scoreboard
package regfile_scoreboard_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    // Decode control word shared with ID/WB; REG_WRITE drives wb_reg_write/id_reg_write.
    localparam int CONTROL_SIGNALS_WIDTH = 12;
    localparam int REG_WRITE             = 0;

    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_pending_counter_bank.sv
// rtl/regfile_scoreboard_pending_counter_bank.sv - per-register in-flight write counters
module pending_counter_bank
    import regfile_scoreboard_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_inc_en,
    input  logic [REG_IDX_W-1:0]     i_inc_idx,
    input  logic                     i_dec_en,
    input  logic [REG_IDX_W-1:0]     i_dec_idx,
    input  logic                     i_flush,
    output logic [NREGS*CNT_W-1:0]   o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] r_cnt [NREGS];
    logic [NREGS-1:0] w_inc;
    logic [NREGS-1:0] w_dec;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_inc[r] = i_inc_en && (i_inc_idx == REG_IDX_W'(r));
            w_dec[r] = i_dec_en && (i_dec_idx == REG_IDX_W'(r));
        end
    end

    // Flush wins over any issue/WB traffic on the same edge; both ends saturate.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            for (int r = 0; r < NREGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_inc[r] && !w_dec[r] && r_cnt[r] != CNT_MAX) begin
                    r_cnt[r] <= r_cnt[r] + 1'b1;
                end else if (w_dec[r] && !w_inc[r] && r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_out
        assign o_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end

    // A write-back with nothing outstanding for that register is a protocol error.
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n || i_flush)
        i_dec_en |-> (r_cnt[i_dec_idx] != '0));

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - integer register file with WB->ID bypass and RAW/overflow stall
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_reg_write,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_reg_write,
    input  logic                 id_issue,
    input  logic                 flush_cnt,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic                 id_stall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [XLEN-1:0]        r_regs [NREGS];
    logic [NREGS*CNT_W-1:0] w_cnt_flat;
    logic [CNT_W-1:0]       w_cnt [NREGS];
    logic                   w_wb_we;
    logic                   w_rdy1;
    logic                   w_rdy2;
    logic                   w_ovf;
    logic                   w_inc_en;

    assign w_wb_we = wb_reg_write && (wb_rd != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else if (w_wb_we) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (id_rs1 != '0) begin
            rs1_data = (w_wb_we && wb_rd == id_rs1) ? wb_data : r_regs[id_rs1];
        end
        if (id_rs2 != '0) begin
            rs2_data = (w_wb_we && wb_rd == id_rs2) ? wb_data : r_regs[id_rs2];
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_cnt
        assign w_cnt[g] = w_cnt_flat[g*CNT_W +: CNT_W];
    end

    // A source with exactly one outstanding write is ready when that write lands now (bypass).
    assign w_rdy1 = (id_rs1 == '0) || (w_cnt[id_rs1] == '0) ||
                    (w_cnt[id_rs1] == CNT_W'(1) && w_wb_we && wb_rd == id_rs1);
    assign w_rdy2 = (id_rs2 == '0) || (w_cnt[id_rs2] == '0) ||
                    (w_cnt[id_rs2] == CNT_W'(1) && w_wb_we && wb_rd == id_rs2);
    assign w_ovf  = id_reg_write && (id_rd != '0) && (w_cnt[id_rd] == CNT_MAX) &&
                    !(w_wb_we && wb_rd == id_rd);

    assign id_stall = id_issue && ((id_rs1_used && !w_rdy1) || (id_rs2_used && !w_rdy2) || w_ovf);
    assign w_inc_en = id_issue && !id_stall && id_reg_write && (id_rd != '0);

    pending_counter_bank #(
        .NREGS (NREGS),
        .CNT_W (CNT_W)
    ) u_cnt_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_inc_en  (w_inc_en),
        .i_inc_idx (id_rd),
        .i_dec_en  (w_wb_we),
        .i_dec_idx (wb_rd),
        .i_flush   (flush_cnt),
        .o_cnt     (w_cnt_flat)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed vector table plus randomized model-based checks
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_reg_write, id_issue, flush_cnt;
    logic [31:0] rs1_data, rs2_data;
    logic        id_stall;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        wbw;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [4:0]  rd;
        logic        rw, iss, fl;
        logic [31:0] e1, e2;
        logic        es;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] m_regs [32];
    int          m_q[$];

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_issue     (id_issue),
        .flush_cnt    (flush_cnt),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .id_stall     (id_stall)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic add(input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic iss, input logic fl,
                       input logic [31:0] e1, input logic [31:0] e2, input logic es);
        vec_t v;
        v.wbw = wbw; v.wbrd = wbrd; v.wbd = wbd; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.rd = rd; v.rw = rw; v.iss = iss; v.fl = fl;
        v.e1 = e1; v.e2 = e2; v.es = es;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        wb_reg_write = v.wbw; wb_rd = v.wbrd; wb_data = v.wbd;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
        id_rd = v.rd; id_reg_write = v.rw; id_issue = v.iss; flush_cnt = v.fl;
    endtask

    task automatic idle();
        vec_t v;
        v = '{default: '0};
        drive(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_q.delete();
    endtask

    function automatic int pending(input int r);
        int c = 0;
        foreach (m_q[i]) if (m_q[i] == r) c++;
        return c;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        //   wbw wbrd wbd           rs1 rs2 u1 u2 rd rw iss fl  e1            e2            es
        add(0, 0, 32'h0,           5,  0,  1, 1, 0, 0, 1, 0, 32'h0,        32'h0,        0);
        add(0, 0, 32'h0,           0,  0,  0, 0, 5, 1, 1, 0, 32'h0,        32'h0,        0);
        add(1, 5, 32'hDEADBEEF,    5,  0,  0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0,        0);
        add(0, 0, 32'h0,           5,  0,  1, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0,        0);
        add(1, 0, 32'hCAFEBABE,    0,  0,  0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0);
        add(0, 0, 32'h0,           0,  5,  1, 1, 0, 0, 1, 0, 32'h0,        32'hDEADBEEF, 0);
        add(0, 0, 32'h0,           0,  0,  0, 0, 7, 1, 1, 0, 32'h0,        32'h0,        0);
        add(0, 0, 32'h0,           0,  7,  0, 1, 0, 0, 1, 0, 32'h0,        32'h0,        1);
        add(1, 7, 32'h12345678,    0,  7,  0, 1, 0, 0, 1, 0, 32'h0,        32'h12345678, 0);
        add(0, 0, 32'h0,           0,  0,  0, 0, 9, 1, 1, 0, 32'h0,        32'h0,        0);
        add(0, 0, 32'h0,           0,  0,  0, 0, 9, 1, 1, 0, 32'h0,        32'h0,        0);
        add(0, 0, 32'h0,           0,  0,  0, 0, 9, 1, 1, 0, 32'h0,        32'h0,        0);
        add(0, 0, 32'h0,           0,  0,  0, 0, 9, 1, 1, 0, 32'h0,        32'h0,        1);
        add(1, 9, 32'h11111111,    9,  0,  0, 0, 9, 1, 1, 0, 32'h11111111, 32'h0,        0);
        add(0, 0, 32'h0,           9,  0,  0, 0, 9, 1, 1, 0, 32'h11111111, 32'h0,        1);
        add(0, 0, 32'h0,           9,  7,  1, 1, 0, 0, 1, 0, 32'h11111111, 32'h12345678, 1);
        add(0, 0, 32'h0,           9,  0,  0, 0, 0, 0, 0, 1, 32'h11111111, 32'h0,        0);
        add(0, 0, 32'h0,           9,  0,  1, 0, 0, 0, 1, 0, 32'h11111111, 32'h0,        0);
        add(0, 0, 32'h0,           0,  0,  0, 0, 3, 1, 1, 0, 32'h0,        32'h0,        0);
        add(0, 0, 32'h0,           0,  0,  0, 0, 3, 1, 1, 0, 32'h0,        32'h0,        0);
        add(0, 0, 32'h0,           3,  0,  1, 0, 0, 0, 1, 0, 32'h0,        32'h0,        1);
        add(1, 3, 32'hA5A5A5A5,    3,  0,  1, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 32'h0,        0);
        add(0, 0, 32'h0,           3,  0,  1, 0, 0, 0, 1, 0, 32'hA5A5A5A5, 32'h0,        0);
        add(0, 0, 32'h0,           3,  0,  1, 0, 3, 1, 1, 0, 32'hA5A5A5A5, 32'h0,        0);
        add(1, 3, 32'h0BADF00D,    3,  0,  1, 0, 0, 0, 1, 0, 32'h0BADF00D, 32'h0,        0);
        add(0, 0, 32'h0,           0,  0,  0, 0, 4, 1, 1, 0, 32'h0,        32'h0,        0);
        add(0, 0, 32'h0,           4,  0,  1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0);
        add(1, 4, 32'h00000044,    0,  4,  0, 0, 0, 0, 0, 0, 32'h0,        32'h00000044, 0);

        do_reset();
        id_rs1 = 5'd5;
        @(negedge clk);
        chk32("reset_rs1", rs1_data, 32'h0);
        chk32("reset_rs2", rs2_data, 32'h0);
        chk1("reset_stall", id_stall, 1'b0);
        step();

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            chk32($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].e1);
            chk32($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].e2);
            chk1($sformatf("vec%0d_stall", i), id_stall, vecs[i].es);
            step();
        end

        // Reset in the middle of traffic: pending x6 and a same-edge WB to x5 are both discarded.
        idle();
        id_issue = 1'b1; id_reg_write = 1'b1; id_rd = 5'd6;
        step();
        idle();
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hFFFFFFFF;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        id_issue = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rs2 = 5'd6; id_rs2_used = 1'b1;
        @(negedge clk);
        chk32("midreset_rs1", rs1_data, 32'h0);
        chk32("midreset_rs2", rs2_data, 32'h0);
        chk1("midreset_stall", id_stall, 1'b0);
        step();

        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            vec_t v;
            int   wb_idx;
            logic hit1, hit2, hitd, rdy1, rdy2, ovf;
            v = '{default: '0};
            wb_idx = -1;
            v.fl = ($urandom_range(0, 31) == 0);
            if (m_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                wb_idx = $urandom_range(0, m_q.size() - 1);
                v.wbw  = 1'b1;
                v.wbrd = 5'(m_q[wb_idx]);
            end else if ($urandom_range(0, 7) == 0) begin
                v.wbw  = 1'b1;
                v.wbrd = 5'd0;
            end else begin
                v.wbrd = 5'($urandom_range(0, 7));
            end
            v.wbd = $urandom;
            v.iss = ($urandom_range(0, 9) < 7);
            v.rs1 = 5'($urandom_range(0, 7));
            v.rs2 = 5'($urandom_range(0, 7));
            v.u1  = 1'($urandom_range(0, 1));
            v.u2  = 1'($urandom_range(0, 1));
            v.rd  = 5'($urandom_range(0, 7));
            v.rw  = 1'($urandom_range(0, 1));

            hit1 = v.wbw && v.wbrd != 0 && v.wbrd == v.rs1;
            hit2 = v.wbw && v.wbrd != 0 && v.wbrd == v.rs2;
            hitd = v.wbw && v.wbrd != 0 && v.wbrd == v.rd;
            v.e1 = (v.rs1 == 0) ? 32'h0 : (hit1 ? v.wbd : m_regs[v.rs1]);
            v.e2 = (v.rs2 == 0) ? 32'h0 : (hit2 ? v.wbd : m_regs[v.rs2]);
            rdy1 = v.rs1 == 0 || pending(int'(v.rs1)) == 0 || (pending(int'(v.rs1)) == 1 && hit1);
            rdy2 = v.rs2 == 0 || pending(int'(v.rs2)) == 0 || (pending(int'(v.rs2)) == 1 && hit2);
            ovf  = v.rw && v.rd != 0 && pending(int'(v.rd)) == 3 && !hitd;
            v.es = v.iss && ((v.u1 && !rdy1) || (v.u2 && !rdy2) || ovf);

            drive(v);
            @(negedge clk);
            chk32($sformatf("rand%0d_rs1", cyc), rs1_data, v.e1);
            chk32($sformatf("rand%0d_rs2", cyc), rs2_data, v.e2);
            chk1($sformatf("rand%0d_stall", cyc), id_stall, v.es);
            step();

            if (v.wbw && v.wbrd != 0) m_regs[v.wbrd] = v.wbd;
            if (v.fl) begin
                m_q.delete();
            end else begin
                if (wb_idx >= 0 && v.wbrd != 0) m_q.delete(wb_idx);
                if (v.iss && !v.es && v.rw && v.rd != 0) m_q.push_back(int'(v.rd));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
